// File: rtl/dbus_master_bridge.sv
// dbus_master_bridge: single-outstanding dbus initiator.
// A local client issues one read or write command. The bridge runs one
// req/ack handshake toward the peripherals and returns the result on a
// valid/ready response port.
// Optional feature: define DBUS_MST_TIMEOUT_EN to abort a request that
// receives no ack within TIMEOUT cycles. Such a request ends with rsp_err_o = 1.

package dbus_pkg;
  typedef struct packed {
    logic        req;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] w_data;
  } type_dbus2peri_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] r_data;
  } type_peri2dbus_s;
endpackage

module dbus_master_bridge
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [31:0]     cmd_addr_i,
  input  logic [31:0]     cmd_wdata_i,
  input  logic            cmd_we_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_rdata_o,
  output logic            rsp_err_o,
  output type_dbus2peri_s dbus2peri_o,
  input  type_peri2dbus_s peri2dbus_i
);

  // Catch illegal TIMEOUT values when the design is elaborated.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range_check
    $error("dbus_master_bridge: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_reg, state_next;
  logic        capture, ack_take, tmo_hit;
  logic        tmo_expire;
  logic        req_reg, we_reg, valid_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;

`ifdef DBUS_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  // Counts BUSY cycles that pass without an ack. The count restarts
  // for every new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      cnt_reg <= '0;
    else if (capture)                                cnt_reg <= '0;
    else if (state_reg == BUSY && !peri2dbus_i.ack)  cnt_reg <= cnt_reg + 1'b1;
  end

  // The abort fires in the cycle where this miss would bring the count to
  // TIMEOUT. As a result, req is high for exactly TIMEOUT cycles.
  assign tmo_expire = (cnt_reg == CW'(TIMEOUT - 1));

  // The error flag changes only when a BUSY phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_reg <= 1'b0;
    else if (ack_take) err_reg <= 1'b0;
    else if (tmo_hit)  err_reg <= 1'b1;
  end

  assign rsp_err_o = err_reg;
`else
  assign tmo_expire = 1'b0;
  assign rsp_err_o  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and the handshake strobes. An ack has priority over an
  // abort in the same cycle.
  always_comb begin
    state_next  = state_reg;
    cmd_ready_o = 1'b0;
    capture     = 1'b0;
    ack_take    = 1'b0;
    tmo_hit     = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (peri2dbus_i.ack) begin
          ack_take   = 1'b1;
          state_next = RESP;
        end else if (tmo_expire) begin
          tmo_hit    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture. These registers drive addr, w_en and w_data directly,
  // so those fields stay stable for the whole of BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
    end else if (capture) begin
      addr_reg  <= cmd_addr_i;
      wdata_reg <= cmd_wdata_i;
      we_reg    <= cmd_we_i;
    end
  end

  // req and rsp_valid are registered decodes of the next state. This keeps
  // them as flop outputs with no combinational path from cmd_* or ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      req_reg   <= (state_next == BUSY);
      valid_reg <= (state_next == RESP);
    end
  end

  // Response data. It is loaded only when a BUSY phase ends, so a stray or
  // late ack seen in another state cannot change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rdata_reg <= '0;
    else if (ack_take) rdata_reg <= we_reg ? 32'h0 : peri2dbus_i.r_data;
    else if (tmo_hit)  rdata_reg <= 32'h0;
  end

  assign rsp_valid_o        = valid_reg;
  assign rsp_rdata_o        = rdata_reg;
  assign dbus2peri_o.req    = req_reg;
  assign dbus2peri_o.w_en   = we_reg;
  assign dbus2peri_o.addr   = addr_reg;
  assign dbus2peri_o.w_data = wdata_reg;

endmodule
